// File: rtl/round_robin_dispatcher_pkg.sv
// Shared defaults for the round-robin dispatcher and its lane holding registers.
package round_robin_dispatcher_pkg;

  localparam int unsigned DEF_NUM_OUT    = 4;
  localparam int unsigned DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/dispatch_lane.sv
// One-entry holding register for a single output lane of the dispatcher.
module dispatch_lane
  import round_robin_dispatcher_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  // A load wins over a drain so a lane emptying this cycle can be refilled at once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/round_robin_dispatcher.sv
// Spreads one valid/ready stream across NUM_OUT lanes in rotation, skipping stalled lanes.
module round_robin_dispatcher
  import round_robin_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_OUT    = DEF_NUM_OUT,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       allow_i,
  input  logic [DATA_WIDTH-1:0]      data_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic [DATA_WIDTH-1:0]      data_o [NUM_OUT],
  output logic [NUM_OUT-1:0]         valid_o,
  input  logic [NUM_OUT-1:0]         ready_i,
  output logic [$clog2(NUM_OUT)-1:0] sel_index_o,
  output logic                       dispatch_o
);

  localparam int unsigned IDX_W = $clog2(NUM_OUT);

  logic [IDX_W-1:0]   rot_index;
  logic [IDX_W-1:0]   rot_next;
  logic [NUM_OUT-1:0] free;
  logic [NUM_OUT-1:0] load;

  assign free       = ~valid_o | ready_i;
  assign ready_o    = allow_i & (|free);
  assign dispatch_o = valid_i & ready_o;

  // Cyclic first-free search starting at rot_index; one extra bit keeps the wrap exact for any NUM_OUT.
  always_comb begin
    logic [IDX_W:0] cand;
    logic           found;
    sel_index_o = rot_index;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      cand = {1'b0, rot_index} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_OUT)) begin
        cand = cand - (IDX_W+1)'(NUM_OUT);
      end
      if (!found && free[cand[IDX_W-1:0]]) begin
        sel_index_o = cand[IDX_W-1:0];
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    rot_next = rot_index;
    load     = '0;
    if (dispatch_o) begin
      load[sel_index_o] = 1'b1;
      rot_next = (sel_index_o == IDX_W'(NUM_OUT - 1)) ? '0 : sel_index_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rot_index <= '0;
    end else begin
      rot_index <= rot_next;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
    dispatch_lane #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (load[k]),
      .data_i (data_i),
      .ready_i(ready_i[k]),
      .valid_o(valid_o[k]),
      .data_o (data_o[k])
    );
  end

endmodule

// File: tb/tb_round_robin_dispatcher.sv
// Self-checking bench for round_robin_dispatcher (4-lane and 3-lane instances).
module tb_round_robin_dispatcher;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       allow_i, valid_i, ready_o, dispatch_o;
  logic [7:0] data_i;
  logic [7:0] data_o [4];
  logic [3:0] valid_o, ready_i;
  logic [1:0] sel_index_o;

  logic       allow3, valid3, ready3_o, disp3;
  logic [7:0] data3;
  logic [7:0] data3_o [3];
  logic [2:0] valid3_o, ready3;
  logic [1:0] sel3;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       allow;
    logic       valid;
    logic [7:0] data;
    logic [3:0] ready;
    logic       exp_ready;
    logic       exp_disp;
    logic [1:0] exp_sel;
  } vec_t;

  typedef struct {
    int         lane;
    logic [7:0] data;
  } sb_t;

  vec_t vecs [10];
  sb_t  sb_q [$];

  always #5 clk_i = ~clk_i;

  round_robin_dispatcher #(.NUM_OUT(4), .DATA_WIDTH(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .allow_i    (allow_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .sel_index_o(sel_index_o),
    .dispatch_o (dispatch_o)
  );

  round_robin_dispatcher #(.NUM_OUT(3), .DATA_WIDTH(8)) dut3 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .allow_i    (allow3),
    .data_i     (data3),
    .valid_i    (valid3),
    .ready_o    (ready3_o),
    .data_o     (data3_o),
    .valid_o    (valid3_o),
    .ready_i    (ready3),
    .sel_index_o(sel3),
    .dispatch_o (disp3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Called at posedge+1; checks handshake outputs mid-cycle, then the scoreboard after the edge.
  task automatic step(input logic al, input logic va, input logic [7:0] d, input logic [3:0] rd,
                      input logic er, input logic ed, input logic [1:0] es, input string nm);
    sb_t e;
    sb_t got;
    allow_i = al; valid_i = va; data_i = d; ready_i = rd;
    @(negedge clk_i);
    chk({nm, ".ready_o"}, 32'(ready_o), 32'(er));
    chk({nm, ".dispatch_o"}, 32'(dispatch_o), 32'(ed));
    if (ed) begin
      chk({nm, ".sel_index_o"}, 32'(sel_index_o), 32'(es));
      e.lane = int'(es);
      e.data = d;
      sb_q.push_back(e);
    end else begin
      chk({nm, ".sel_idle"}, 32'(sel_index_o), 32'(es));
    end
    @(posedge clk_i); #1;
    while (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      chk({nm, ".lane_data"}, 32'(data_o[got.lane]), 32'(got.data));
      chk({nm, ".lane_valid"}, 32'(valid_o[got.lane]), 32'd1);
    end
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1; allow_i = 1'b0; valid_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; allow_i = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = '0;
    allow3 = 1'b0; valid3 = 1'b0; data3 = '0; ready3 = '0;

    // Streaming table plus idle and blocked vectors
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 1'b1, 8'(8'h10 + i), 4'hF, 1'b1, 1'b1, 2'(i % 4)};
    end
    vecs[8] = '{1'b1, 1'b0, 8'h00, 4'hF, 1'b1, 1'b0, 2'd0};
    vecs[9] = '{1'b0, 1'b1, 8'h99, 4'hF, 1'b0, 1'b0, 2'd0};

    do_reset(2);

    // Reset with lanes holding data
    step(1'b1, 1'b1, 8'h11, 4'h0, 1'b1, 1'b1, 2'd0, "pre0");
    step(1'b1, 1'b1, 8'h22, 4'h0, 1'b1, 1'b1, 2'd1, "pre1");
    chk("pre.valid_o", 32'(valid_o), 32'h3);
    do_reset(2);
    chk("rst.valid_o", 32'(valid_o), 32'h0);
    chk("rst.data0", 32'(data_o[0]), 32'h0);
    chk("rst.data1", 32'(data_o[1]), 32'h0);
    step(1'b1, 1'b1, 8'hA0, 4'h0, 1'b1, 1'b1, 2'd0, "rst_a0");

    // Back-to-back streaming, all lanes ready
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].allow, vecs[i].valid, vecs[i].data, vecs[i].ready,
           vecs[i].exp_ready, vecs[i].exp_disp, vecs[i].exp_sel, $sformatf("vec%0d", i));
    end

    // Skip stalled lane 1
    do_reset(1);
    step(1'b1, 1'b1, 8'h44, 4'b1101, 1'b1, 1'b1, 2'd0, "skip_a");
    step(1'b1, 1'b1, 8'h55, 4'b1101, 1'b1, 1'b1, 2'd1, "skip_b");
    step(1'b1, 1'b1, 8'h56, 4'b1101, 1'b1, 1'b1, 2'd2, "skip_c");
    step(1'b1, 1'b1, 8'h57, 4'b1101, 1'b1, 1'b1, 2'd3, "skip_d");
    step(1'b1, 1'b1, 8'h58, 4'b1101, 1'b1, 1'b1, 2'd0, "skip_e");
    step(1'b1, 1'b1, 8'h66, 4'b1101, 1'b1, 1'b1, 2'd2, "skip_66");
    chk("skip.hold1", 32'(data_o[1]), 32'h55);
    chk("skip.valid1", 32'(valid_o[1]), 32'd1);
    step(1'b1, 1'b0, 8'h00, 4'b1101, 1'b1, 1'b0, 2'd3, "skip_rot");

    // Fill all lanes, stall, then drain and reload lane 2 in one cycle
    step(1'b1, 1'b1, 8'h70, 4'h0, 1'b1, 1'b1, 2'd3, "fill_a");
    step(1'b1, 1'b1, 8'h71, 4'h0, 1'b1, 1'b1, 2'd0, "fill_b");
    step(1'b1, 1'b1, 8'h72, 4'h0, 1'b1, 1'b1, 2'd2, "fill_c");
    chk("full.valid_o", 32'(valid_o), 32'hF);
    step(1'b1, 1'b1, 8'h7F, 4'h0, 1'b0, 1'b0, 2'd3, "full_stall");
    chk("full.hold2", 32'(data_o[2]), 32'h72);
    step(1'b1, 1'b1, 8'h77, 4'b0100, 1'b1, 1'b1, 2'd2, "reload");
    chk("reload.valid_o", 32'(valid_o), 32'hF);
    chk("reload.hold1", 32'(data_o[1]), 32'h55);

    // allow_i low: no acceptance, lanes drain, rotation frozen
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'hEE, 4'hF, 1'b0, 1'b0, 2'd3, $sformatf("block%0d", i));
    end
    chk("block.valid_o", 32'(valid_o), 32'h0);
    step(1'b1, 1'b1, 8'h88, 4'hF, 1'b1, 1'b1, 2'd3, "unblock");

    // Three-lane wrap
    allow_i = 1'b0; valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      allow3 = 1'b1; valid3 = 1'b1; data3 = 8'(8'h30 + i); ready3 = 3'b111;
      @(negedge clk_i);
      chk($sformatf("n3.sel%0d", i), 32'(sel3), 32'(i % 3));
      chk($sformatf("n3.disp%0d", i), 32'(disp3), 32'd1);
      @(posedge clk_i); #1;
      chk($sformatf("n3.data%0d", i), 32'(data3_o[i % 3]), 32'(8'h30 + i));
      chk($sformatf("n3.valid%0d", i), 32'(valid3_o[i % 3]), 32'd1);
    end
    valid3 = 1'b0;
    @(negedge clk_i);
    chk("n3.rot", 32'(sel3), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
